// File: rtl/req_issue_ctrl.sv
// req_issue_ctrl: buffers addr/data commands and issues them to an ack/rdy target with timeout and bounded retry
module req_issue_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_req,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     tgt_rdy,
  input  logic                     tgt_ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_mem_a [DEPTH];
  logic [DATA_W-1:0]   r_mem_d [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_count;
  logic [TW-1:0]       r_timer;
  logic [RW-1:0]       r_retry;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                w_push, w_pop, w_load, w_drop, w_retry, w_expire;

  assign in_ready = r_count < CW'(DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_expire = r_timer == TW'(TIMEOUT - 1);
  assign out_req  = r_state == REQ;
  assign out_addr = r_addr;
  assign out_data = r_data;
  assign err      = r_err;
  assign count    = r_count;
  assign busy     = (r_count != '0) || (r_state != IDLE);

  // Next state and per-cycle FIFO/issue strobes; ack beats a same-cycle timeout
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_load  = 1'b0;
    w_drop  = 1'b0;
    w_retry = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = (r_count != '0) && tgt_rdy;
        w_next = w_load ? REQ : IDLE;
      end
      REQ: begin
        w_drop  = !tgt_ack && w_expire && (r_retry == RW'(MAX_RETRY));
        w_retry = !tgt_ack && w_expire && !w_drop;
        w_pop   = tgt_ack || w_drop;
        w_next  = w_pop ? IDLE : (w_retry ? GAP : REQ);
      end
      GAP: begin
        w_load = tgt_rdy;
        w_next = tgt_rdy ? REQ : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk)
    if (w_push) begin
      r_mem_a[r_wp] <= in_addr;
      r_mem_d[r_wp] <= in_data;
    end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  // Attempt timer, retry counter (kept across IDLE, cleared when the head leaves) and error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_timer <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      r_timer <= w_load ? '0 : (r_state == REQ ? r_timer + 1'b1 : r_timer);
      r_retry <= w_pop ? '0 : (w_retry ? r_retry + 1'b1 : r_retry);
      r_err   <= w_drop;
    end

  // Registered target address/data, loaded from the FIFO head on each issue
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_addr <= r_mem_a[r_rp];
      r_data <= r_mem_d[r_rp];
    end
endmodule

// File: tb/tb_req_issue_ctrl.sv
// tb_req_issue_ctrl: directed scenarios plus random traffic checked against a queue-based model
module tb_req_issue_ctrl;
  localparam int AW = 8, DW = 32, DEPTH = 4, TO = 15, MR = 2, CW = $clog2(DEPTH) + 1;

  logic clk = 0, rst = 0, in_valid = 0, tgt_rdy = 0, tgt_ack = 0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_req, err, busy;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  req_issue_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .out_req(out_req), .out_addr(out_addr), .out_data(out_data),
    .tgt_rdy(tgt_rdy), .tgt_ack(tgt_ack), .err(err), .busy(busy), .count(count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  bit m_req, m_gap, m_err, last_push;
  int m_len, m_tries, req_cycles, err_pulses;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qd.delete();
    m_req = 0; m_gap = 0; m_err = 0; m_len = 0; m_tries = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic compare();
    chk("out_req", out_req, m_req);
    chk("err", err, m_err);
    chk("count", count, qa.size());
    chk("in_ready", in_ready, qa.size() < DEPTH);
    chk("busy", busy, qa.size() != 0 || m_req || m_gap);
    chk("out_addr", out_addr, m_addr);
    chk("out_data", out_data, m_data);
    if (out_req) req_cycles++;
    if (err) err_pulses++;
  endtask

  task automatic issue();
    m_req = 1; m_len = 1; m_addr = qa[0]; m_data = qd[0];
  endtask

  task automatic drop_head();
    void'(qa.pop_front());
    void'(qd.pop_front());
  endtask

  // Advance one clock: predict from the inputs in force, then check the DUT just after the edge
  task automatic step();
    last_push = in_valid && qa.size() < DEPTH;
    m_err = 0;
    if (m_req) begin
      if (tgt_ack) begin
        drop_head(); m_req = 0; m_tries = 0;
      end else if (m_len == TO) begin
        m_req = 0;
        if (m_tries == MR) begin drop_head(); m_err = 1; m_tries = 0; end
        else begin m_tries++; m_gap = 1; end
      end else m_len++;
    end else if (m_gap) begin
      m_gap = 0;
      if (tgt_rdy) issue();
    end else if (qa.size() != 0 && tgt_rdy) issue();
    if (last_push) begin qa.push_back(in_addr); qd.push_back(in_data); end
    @(posedge clk); #1;
    compare();
  endtask

  task automatic wait_req(int max);
    for (int i = 0; i < max && !out_req; i++) step();
    chk("wait_req", out_req, 1'b1);
  endtask

  initial begin
    #1 rst = 1;
    model_reset();
    #20;
    compare();
    @(posedge clk); #1 rst = 0;

    // single command, ack on third cycle of the request
    req_cycles = 0; err_pulses = 0;
    in_valid = 1; in_addr = 8'hA5; in_data = 32'hDEADBEEF; tgt_rdy = 1;
    step();
    in_valid = 0;
    step();
    chk("latency_req", out_req, 1'b1);
    step(); step();
    tgt_ack = 1; step(); tgt_ack = 0;
    chk("single_req_cycles", req_cycles, 3);
    chk("single_busy", busy, 1'b0);
    chk("single_err", err_pulses, 0);

    // five back-to-back pushes with target stalled, then drain in order
    tgt_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_addr = AW'($urandom); in_data = $urandom;
      step();
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 1'b0);
    tgt_rdy = 1;
    for (int i = 0; i < 30; i++) begin
      tgt_ack = out_req;
      step();
      if (last_push) in_valid = 0;
    end
    tgt_ack = 0;
    chk("drain_count", count, 0);

    // never acknowledged: three full windows then a drop
    req_cycles = 0; err_pulses = 0;
    in_valid = 1; in_addr = AW'($urandom); in_data = $urandom;
    step(); in_valid = 0;
    for (int i = 0; i < 60; i++) step();
    chk("timeout_req_cycles", req_cycles, 3 * TO);
    chk("timeout_err_pulses", err_pulses, 1);
    chk("timeout_count", count, 0);

    // ack on the last cycle of the final retry window
    req_cycles = 0; err_pulses = 0;
    in_valid = 1; in_addr = AW'($urandom); in_data = $urandom;
    step(); in_valid = 0;
    for (int i = 0; i < 80; i++) begin
      tgt_ack = m_req && m_len == TO && m_tries == MR;
      step();
    end
    tgt_ack = 0;
    chk("late_ack_req_cycles", req_cycles, 3 * TO);
    chk("late_ack_err_pulses", err_pulses, 0);
    chk("late_ack_count", count, 0);

    // full FIFO: push blocked in the pop cycle, accepted the next
    tgt_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_addr = AW'($urandom); in_data = $urandom;
      step();
    end
    in_valid = 0; tgt_rdy = 1;
    wait_req(5);
    in_valid = 1; in_addr = AW'($urandom); in_data = $urandom; tgt_ack = 1;
    step();
    chk("full_pop_count", count, 3);
    tgt_ack = 0;
    step();
    chk("full_refill_count", count, 4);
    in_valid = 0;
    for (int i = 0; i < 30; i++) begin tgt_ack = out_req; step(); end
    tgt_ack = 0;

    // reset in the middle of a request
    tgt_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_addr = AW'($urandom); in_data = $urandom;
      step();
    end
    in_valid = 0; tgt_rdy = 1;
    wait_req(5);
    chk("pre_rst_count", count, 2);
    #2 rst = 1;
    #1 model_reset();
    chk("rst_out_req", out_req, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst = 0;
    req_cycles = 0; err_pulses = 0;
    for (int i = 0; i < 10; i++) begin tgt_ack = i[0]; step(); end
    tgt_ack = 0;
    chk("post_rst_req_cycles", req_cycles, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_addr  = AW'($urandom);
      in_data  = $urandom;
      tgt_rdy  = $urandom_range(0, 3) != 0;
      tgt_ack  = $urandom_range(0, 9) < 2;
      step();
    end
    in_valid = 0; tgt_rdy = 1;
    for (int i = 0; i < 200; i++) begin tgt_ack = out_req; step(); end
    tgt_ack = 0;
    chk("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
